// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// The result is computed when the op is accepted and committed to HI/LO after the busy latency.
module mult_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} stateT;

  stateT            state;
  stateT            stateNext;
  logic [CNT_W-1:0] counter;
  logic [31:0]      pendHi;
  logic [31:0]      pendLo;
  logic             pendWrite;

  logic             accept;
  logic             finish;
  logic             moveHi;
  logic             moveLo;

  logic             opSigned;
  logic             isDiv;
  logic [63:0]      mulA;
  logic [63:0]      mulB;
  logic [63:0]      product;
  logic [31:0]      magA;
  logic [31:0]      magB;
  logic [31:0]      divisor;
  logic [31:0]      qMag;
  logic [31:0]      rMag;
  logic [31:0]      quotient;
  logic [31:0]      remainder;

  // Next-state logic and the accept/finish/move strobes that drive the datapath.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    finish    = 1'b0;
    moveHi    = 1'b0;
    moveLo    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            accept    = 1'b1;
            stateNext = RUN;
          end
          moveHi = (op == 3'd4);
          moveLo = (op == 3'd5);
        end
      end
      RUN: begin
        if (counter == '0) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Signed ops work on magnitudes; 0x80000000/-1 wraps naturally to 0x80000000 rem 0.
  always_comb begin
    opSigned  = ~op[0];
    isDiv     = op[1];
    mulA      = opSigned ? {{32{srcA[31]}}, srcA} : {32'b0, srcA};
    mulB      = opSigned ? {{32{srcB[31]}}, srcB} : {32'b0, srcB};
    product   = mulA * mulB;
    magA      = (opSigned && srcA[31]) ? (~srcA + 32'd1) : srcA;
    magB      = (opSigned && srcB[31]) ? (~srcB + 32'd1) : srcB;
    divisor   = (magB == 32'd0) ? 32'd1 : magB;
    qMag      = magA / divisor;
    rMag      = magA % divisor;
    quotient  = (opSigned && (srcA[31] ^ srcB[31])) ? (~qMag + 32'd1) : qMag;
    remainder = (opSigned && srcA[31]) ? (~rMag + 32'd1) : rMag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Datapath: pending result capture, countdown, and HI/LO commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter   <= '0;
      pendHi    <= 32'd0;
      pendLo    <= 32'd0;
      pendWrite <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        counter   <= isDiv ? DIV_LOAD : MUL_LOAD;
        pendHi    <= isDiv ? remainder : product[63:32];
        pendLo    <= isDiv ? quotient : product[31:0];
        pendWrite <= !(isDiv && (srcB == 32'd0));
      end else if (state == RUN && !finish) begin
        counter <= counter - CNT_W'(1);
      end
      if (finish && pendWrite) begin
        hi <= pendHi;
        lo <= pendLo;
      end
      if (moveHi) begin
        hi <= srcA;
      end
      if (moveLo) begin
        lo <= srcA;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int cycles;
  logic sawDone;
  logic sawWrite;

  mult_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one start strobe for a single cycle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = opIn;
    srcA  = a;
    srcB  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitBusy(output int count);
    count = 0;
    while (busy === 1'b1 && count < 200) begin
      count++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    srcA  = 32'd0;
    srcB  = 32'd0;
    #12;
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetHi", hi, 32'd0);
    checkOutput("resetLo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // MULT -2*3
    applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3);
    waitBusy(cycles);
    checkOutput("multCycles", cycles, MUL_N);
    checkOutput("multDone", {31'd0, done}, 32'd1);
    checkOutput("multHi", hi, 32'hFFFFFFFF);
    checkOutput("multLo", lo, 32'hFFFFFFFA);
    @(negedge clk);
    checkOutput("multDoneDrop", {31'd0, done}, 32'd0);

    applyStimulus(OP_MULTU, 32'hFFFFFFFE, 32'd3);
    waitBusy(cycles);
    checkOutput("multuCycles", cycles, MUL_N);
    checkOutput("multuHi", hi, 32'h00000002);
    checkOutput("multuLo", lo, 32'hFFFFFFFA);

    // Reserved op leaves everything alone
    applyStimulus(3'd6, 32'h1234, 32'd5);
    checkOutput("rsvBusy", {31'd0, busy}, 32'd0);
    checkOutput("rsvHi", hi, 32'h00000002);
    checkOutput("rsvLo", lo, 32'hFFFFFFFA);

    // Signed and unsigned divides
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2);
    waitBusy(cycles);
    checkOutput("divCycles", cycles, DIV_N);
    checkOutput("divDone", {31'd0, done}, 32'd1);
    checkOutput("divLo", lo, 32'hFFFFFFFD);
    checkOutput("divHi", hi, 32'hFFFFFFFF);

    applyStimulus(OP_DIV, 32'd7, 32'hFFFFFFFE);
    waitBusy(cycles);
    checkOutput("divNegBLo", lo, 32'hFFFFFFFD);
    checkOutput("divNegBHi", hi, 32'd1);

    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    waitBusy(cycles);
    checkOutput("divuCycles", cycles, DIV_N);
    checkOutput("divuLo", lo, 32'd14);
    checkOutput("divuHi", hi, 32'd2);

    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitBusy(cycles);
    checkOutput("divOvfLo", lo, 32'h80000000);
    checkOutput("divOvfHi", hi, 32'd0);

    // Divide by zero keeps preloaded HI/LO
    applyStimulus(OP_MTHI, 32'h11, 32'd0);
    checkOutput("mthiBusy", {31'd0, busy}, 32'd0);
    applyStimulus(OP_MTLO, 32'h22, 32'd0);
    checkOutput("mtHi", hi, 32'h11);
    checkOutput("mtLo", lo, 32'h22);
    applyStimulus(OP_DIV, 32'd5, 32'd0);
    waitBusy(cycles);
    checkOutput("div0Cycles", cycles, DIV_N);
    checkOutput("div0Done", {31'd0, done}, 32'd1);
    checkOutput("div0Hi", hi, 32'h11);
    checkOutput("div0Lo", lo, 32'h22);

    // Busy interlock, then MTHI in the done cycle
    applyStimulus(OP_MULT, 32'd6, 32'd7);
    start = 1'b1;
    op    = OP_MTLO;
    srcA  = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    waitBusy(cycles);
    checkOutput("lockCycles", cycles, MUL_N - 1);
    checkOutput("lockDone", {31'd0, done}, 32'd1);
    checkOutput("lockLo", lo, 32'd42);
    checkOutput("lockHi", hi, 32'd0);
    start = 1'b1;
    op    = OP_MTHI;
    srcA  = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    checkOutput("doneMthiHi", hi, 32'hBEEF);
    checkOutput("doneMthiLo", lo, 32'd42);
    checkOutput("doneMthiBusy", {31'd0, busy}, 32'd0);

    // Asynchronous reset with HI/LO nonzero
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncHi", hi, 32'd0);
    checkOutput("asyncLo", lo, 32'd0);
    checkOutput("asyncBusy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a divide
    applyStimulus(OP_MTHI, 32'h55, 32'd0);
    applyStimulus(OP_MTLO, 32'h66, 32'd0);
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    checkOutput("midBusyBefore", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midBusy", {31'd0, busy}, 32'd0);
    checkOutput("midHi", hi, 32'd0);
    checkOutput("midLo", lo, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    sawDone  = 1'b0;
    sawWrite = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done !== 1'b0) sawDone = 1'b1;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) sawWrite = 1'b1;
    end
    checkOutput("noLateDone", {31'd0, sawDone}, 32'd0);
    checkOutput("noLateWrite", {31'd0, sawWrite}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
